// File: rtl/pong_msg_pkg.sv
// Shared types and constants for the pong inter-board message link.
// Used by both the transmit framer and the receiver.
package pong_msg_pkg;

  localparam int DEFAULT_BIT_CYCLES = 434;

  typedef enum logic [1:0] {
    BALL         = 2'b00,
    MISS         = 2'b01,
    NEW_GAME     = 2'b10,
    NEW_GAME_ACK = 2'b11
  } msg_type_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [2:0] LEN_BALL         = 3'd3;
  localparam logic [2:0] LEN_MISS         = 3'd2;
  localparam logic [2:0] LEN_NEW_GAME     = 3'd1;
  localparam logic [2:0] LEN_NEW_GAME_ACK = 3'd1;

  localparam logic [2:0] LEN_BALL_CK         = 3'd4;
  localparam logic [2:0] LEN_MISS_CK         = 3'd3;
  localparam logic [2:0] LEN_NEW_GAME_CK     = 3'd2;
  localparam logic [2:0] LEN_NEW_GAME_ACK_CK = 3'd2;

endpackage

// File: rtl/pong_msg_tx_uart.sv
// 8N1 LSB-first byte serializer; a byte is taken only while cts_i is high,
// either from idle or on the last cycle of a stop bit (back-to-back bytes).
module uart_byte_tx
  import pong_msg_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       cts_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_end;
  logic          take;

  assign baud_end = (baud_q == BAUD_LAST);
  assign done_o   = (state_q == STOP) && baud_end;
  assign ready_o  = cts_i && ((state_q == IDLE) || done_o);
  assign take     = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_o   = 1'b1;
    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
      end
      START: begin
        txd_o = 1'b0;
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        txd_o = shift_q[0];
        if (baud_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new byte overrides the return to idle at the end of a stop bit
    if (take) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = 3'd0;
      shift_d = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/pong_msg_tx.sv
// Game message framer feeding a UART serializer (8N1, LSB first).
// Define PONG_MSG_CHECKSUM_EN to append an XOR checksum byte to every frame.
module pong_msg_tx
  import pong_msg_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_new_message,
  output logic       message_sent,
  input  logic       ball_message_tx,
  input  logic       miss_message_tx,
  input  logic       new_game_message_tx,
  input  logic       new_game_ack_message_tx,
  input  logic [8:0] ball_y_tx,
  input  logic [3:0] velocity_x_tx,
  input  logic [3:0] velocity_y_tx,
  input  logic       sign_y_tx,
  input  logic [4:0] my_score_tx,
  input  logic [4:0] your_score_tx,
  input  logic       you_should_serve_tx,
  input  logic       you_serve_first_tx,
  input  logic       cts,
  output logic       uart_txd
);

`ifdef PONG_MSG_CHECKSUM_EN
  localparam logic [2:0] L_BALL = LEN_BALL_CK;
  localparam logic [2:0] L_MISS = LEN_MISS_CK;
  localparam logic [2:0] L_NG   = LEN_NEW_GAME_CK;
  localparam logic [2:0] L_ACK  = LEN_NEW_GAME_ACK_CK;
`else
  localparam logic [2:0] L_BALL = LEN_BALL;
  localparam logic [2:0] L_MISS = LEN_MISS;
  localparam logic [2:0] L_NG   = LEN_NEW_GAME;
  localparam logic [2:0] L_ACK  = LEN_NEW_GAME_ACK;
`endif

  msg_type_t  type_d;
  logic       any_flag;
  logic       accept;
  logic       busy_q, busy_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] len_q, len_d;
  logic [7:0] frame_d [4];
  logic [7:0] frame_q [4];
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       xfer;

  assign any_flag = ball_message_tx | miss_message_tx |
                    new_game_message_tx | new_game_ack_message_tx;
  assign accept   = send_new_message && any_flag && !busy_q;
  assign message_sent = !busy_q;

  always_comb begin
    type_d = BALL;
    priority case (1'b1)
      new_game_message_tx:     type_d = NEW_GAME;
      new_game_ack_message_tx: type_d = NEW_GAME_ACK;
      miss_message_tx:         type_d = MISS;
      default:                 type_d = BALL;
    endcase
  end

  always_comb begin
`ifdef PONG_MSG_CHECKSUM_EN
    logic [7:0] ck;
`endif
    for (int i = 0; i < 4; i++) frame_d[i] = 8'h00;
    len_d = L_BALL;
    unique case (type_d)
      BALL: begin
        frame_d[0] = {2'b00, ball_y_tx[8:3]};
        frame_d[1] = {ball_y_tx[2:0], sign_y_tx, velocity_y_tx};
        frame_d[2] = {4'h0, velocity_x_tx};
        len_d      = L_BALL;
      end
      MISS: begin
        frame_d[0] = {2'b01, 1'b0, my_score_tx};
        frame_d[1] = {2'b00, you_should_serve_tx, your_score_tx};
        len_d      = L_MISS;
      end
      NEW_GAME: begin
        frame_d[0] = {2'b10, 5'b0, you_serve_first_tx};
        len_d      = L_NG;
      end
      NEW_GAME_ACK: begin
        frame_d[0] = {2'b11, 6'b0};
        len_d      = L_ACK;
      end
      default: len_d = L_BALL;
    endcase
`ifdef PONG_MSG_CHECKSUM_EN
    // Unused slots are zero, so XOR over all four equals XOR of the payload
    ck = frame_d[0] ^ frame_d[1] ^ frame_d[2] ^ frame_d[3];
    frame_d[2'(len_d - 3'd1)] = ck;
`endif
  end

  assign tx_data  = busy_q ? frame_q[idx_q[1:0]] : frame_d[0];
  assign tx_valid = accept || (busy_q && (idx_q < len_q));
  assign xfer     = tx_valid && tx_ready;

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    if (accept) begin
      busy_d = 1'b1;
      idx_d  = {2'b00, xfer};
    end else if (busy_q) begin
      if (xfer) idx_d = idx_q + 3'd1;
      if (tx_done && (idx_q == len_q)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      idx_q  <= 3'd0;
      len_q  <= 3'd0;
      for (int i = 0; i < 4; i++) frame_q[i] <= 8'h00;
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      if (accept) begin
        len_q <= len_d;
        for (int i = 0; i < 4; i++) frame_q[i] <= frame_d[i];
      end
    end
  end

  uart_byte_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tx (
    .clk_i  (clock),
    .rst_i  (reset),
    .data_i (tx_data),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .cts_i  (cts),
    .txd_o  (uart_txd),
    .done_o (tx_done)
  );

endmodule

// File: doc/pong_msg_tx.md
# pong_msg_tx

Transmit-side message framer and UART serializer behind the game-state logic's send handshake. It accepts one game message at a time (ball hand-off, miss/score, new game, new-game ack), packs it into a 1–3 byte frame, and shifts the frame out on the UART TX line as 8N1, LSB first. It drives the board's UART_TXD and is the producer-facing half of the inter-board link.

## Interface
- BIT_CYCLES, 434: clock cycles per UART bit (50 MHz / 115200).
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- send_new_message  in  1  request; fields below are valid while it is high.
- message_sent  out  1  ready/idle: a request is accepted on a clock edge where both are high.
- ball_message_tx, miss_message_tx, new_game_message_tx, new_game_ack_message_tx  in  1 each  message type select.
- ball_y_tx  in  9; velocity_x_tx  in  4; velocity_y_tx  in  4; sign_y_tx  in  1: ball fields.
- my_score_tx  in  5; your_score_tx  in  5; you_should_serve_tx  in  1: miss fields.
- you_serve_first_tx  in  1: new-game field.
- cts  in  1  clear-to-send; a new byte's start bit begins only while high.
- uart_txd  out  1  serial line, idle high.

## Operation
- States: IDLE, START, DATA, STOP. The byte index counts 0..N-1, the bit counter counts 0..7, and the baud counter counts 0..BIT_CYCLES-1.
- IDLE: message_sent=1 and uart_txd=1. On acceptance, the block latches all fields and the type, clears message_sent, and loads byte 0.
- Type priority when several flags are high: new_game > new_game_ack > miss > ball. If no flag is high, the request is ignored and the block stays in IDLE with message_sent=1.
- Frames (B0 first):
  - BALL, 3 bytes: B0={2'b00, ball_y[8:3]}, B1={ball_y[2:0], sign_y, vel_y}, B2={4'h0, vel_x}.
  - MISS, 2 bytes: B0={2'b01, 1'b0, my_score}, B1={2'b00, you_should_serve, your_score}.
  - NEW_GAME, 1 byte: {2'b10, 5'b0, you_serve_first}.
  - NEW_GAME_ACK, 1 byte: {2'b11, 6'b0}.
- START: the block enters START from IDLE or STOP only when cts=1. If cts=0, it holds the line high and waits indefinitely. In START, uart_txd=0 for BIT_CYCLES.
- DATA: bits 0..7 are sent LSB first, BIT_CYCLES each.
- STOP: uart_txd=1 for BIT_CYCLES. At the end of STOP:
  - If more bytes remain, the block moves to START (gated by cts).
  - Otherwise it returns to IDLE.
- Input changes after acceptance have no effect on the frame in flight.
- Reset mid-frame: on reset, uart_txd goes to 1 and message_sent to 1 immediately. The partial frame is abandoned and the receiver discards it by framing error or timeout.

## Timing
- Reset values: state=IDLE, uart_txd=1, message_sent=1, all counters 0.
- Acceptance at edge k: message_sent=0 and uart_txd=0 (start bit) from edge k+1, provided cts=1.
- With cts held high, an N-byte frame occupies exactly N·10·BIT_CYCLES cycles, with no idle gap between bytes.
- message_sent rises on the edge that ends the last stop bit. The next acceptance can occur on the following edge, so there is at least one idle cycle between frames.
- message_sent never rises while a frame is partially sent.

## Configuration
- PONG_MSG_CHECKSUM_EN:
  - Defined: the block appends one extra byte to every frame, the XOR of all preceding frame bytes. Frame lengths become 4/3/2/2 bytes.
  - Undefined: no checksum byte; lengths are 3/2/1/1.
- The macro changes nothing else, including the handshake.

## Structure
- Package pong_msg_pkg holds:
  - msg_type_t enum (BALL=2'b00, MISS=2'b01, NEW_GAME=2'b10, NEW_GAME_ACK=2'b11);
  - per-type frame-length constants, including checksum variants;
  - the default BIT_CYCLES.
  The receiver will share this package.
- Sub-module uart_byte_tx: an 8N1 serializer with a byte/valid/ready handshake and the cts gate. pong_msg_tx holds the type priority, the latched frame bytes, the byte index and the checksum.

## Test plan
- BIT_CYCLES=4, cts=1: NEW_GAME with you_serve_first=1 → one byte 0x81 on uart_txd in 40 cycles; message_sent low for exactly 40 cycles.
- BALL with ball_y=9'h1A5, sign_y=1, vel_y=4'h3, vel_x=4'h5 → bytes 0x34, 0xB3, 0x05 back-to-back in 120 cycles.
- MISS with my=5'd7, your=5'd12, serve=1 → bytes 0x47, 0x2C. Toggling the inputs mid-frame does not change the output.
- Ball and miss flags both high → MISS frame sent. No flag high → no line activity and message_sent stays 1.
- cts dropped during B0's stop bit of a BALL frame → line stays high until cts=1, then B1 starts. Reset asserted mid-B1 → uart_txd=1 and message_sent=1 immediately.
- PONG_MSG_CHECKSUM_EN defined: NEW_GAME_ACK → bytes 0xC0, 0xC0. The BALL frame above gains trailer byte 0x82.
